// File: rtl/lc3_mem_responder_if.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// lc3_mem_responder_if : LC3 memory bus (request out of master, response in)
// Rev 1.0
// ---------------------------------------------------------------------------
interface lc3_mem_responder_if;
  logic        rd;
  logic [15:0] addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        complete;

  modport master (output rd, output addr, output din, input dout, input complete);
  modport slave  (input rd, input addr, input din, output dout, output complete);
endinterface
`default_nettype wire

// File: rtl/lc3_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// lc3_mem_responder : memory-side responder, fixed-latency read/write + preload
// Rev 1.0
// ---------------------------------------------------------------------------
module lc3_mem_responder #(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 3
) (
  input  wire logic        clock,
  input  wire logic        reset,
  lc3_mem_responder_if.slave bus,
  input  wire logic        load_en,
  input  wire logic [15:0] load_addr,
  input  wire logic [15:0] load_data
);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
      $fatal(1, "lc3_mem_responder: LATENCY must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);
  localparam int         C_DEPTH    = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_req_rd;
  logic [15:0] r_req_addr;
  logic [15:0] r_req_din;
  logic [15:0] r_dout;
  logic        r_complete;
  logic [15:0] r_mem [0:C_DEPTH-1];

  logic              w_req_changed;
  logic              w_access;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_idx;
  logic [15:0]       w_mem_wdata;

  // The full 16-bit address takes part in the change test, so a master
  // moving between aliases of the same word still restarts the access.
  assign w_req_changed = ({bus.rd, bus.addr, bus.din} != {r_req_rd, r_req_addr, r_req_din});
  assign w_access      = (r_state == S_WAIT) && !w_req_changed && (r_cnt == 4'd0);

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = r_req_addr[ADDR_W-1:0];
    w_mem_wdata = r_req_din;
    if (!reset) begin
      if (load_en) begin
        w_mem_we    = 1'b1;
        w_mem_idx   = load_addr[ADDR_W-1:0];
        w_mem_wdata = load_data;
      end else if (w_access && !r_req_rd) begin
        w_mem_we = 1'b1;
      end
    end
  end

  // Contents deliberately survive reset; only the preload port and
  // completing writes ever modify them.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_req_rd   <= 1'b0;
      r_req_addr <= 16'h0000;
      r_req_din  <= 16'h0000;
      r_dout     <= 16'h0000;
      r_complete <= 1'b0;
    end else if (load_en) begin
      r_complete <= 1'b0;
      r_state    <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_rd   <= bus.rd;
          r_req_addr <= bus.addr;
          r_req_din  <= bus.din;
          r_cnt      <= C_CNT_INIT;
          r_complete <= 1'b0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (w_req_changed) begin
            r_req_rd   <= bus.rd;
            r_req_addr <= bus.addr;
            r_req_din  <= bus.din;
            r_cnt      <= C_CNT_INIT;
          end else if (r_cnt == 4'd0) begin
            if (r_req_rd) begin
              r_dout <= r_mem[r_req_addr[ADDR_W-1:0]];
            end
            r_complete <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_req_rd   <= bus.rd;
          r_req_addr <= bus.addr;
          r_req_din  <= bus.din;
          r_cnt      <= C_CNT_INIT;
          r_complete <= 1'b0;
          r_state    <= S_WAIT;
        end
        default: begin
          r_complete <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dout     = r_dout;
  assign bus.complete = r_complete;

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_lc3_mem_responder : directed tests for the LC3 memory responder
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_lc3_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [15:0] load_addr;
  logic [15:0] load_data;
  logic        load6_en;
  logic [15:0] load6_addr;
  logic [15:0] load6_data;
  int          checks   = 0;
  int          failures = 0;
  int          cyc;

  lc3_mem_responder_if bus ();
  lc3_mem_responder_if bus6 ();

  lc3_mem_responder #(.ADDR_W(16), .LATENCY(3)) u_dut (
    .clock     (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  lc3_mem_responder #(.ADDR_W(8), .LATENCY(1)) u_dut6 (
    .clock     (clk),
    .reset     (reset),
    .bus       (bus6.slave),
    .load_en   (load6_en),
    .load_addr (load6_addr),
    .load_data (load6_data)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  // Returns the number of edges until complete is seen high, or -1 on timeout.
  task automatic wait_complete(input bit sel, output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if ((sel ? bus6.complete : bus.complete) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.complete !== 1'b0) begin
      failures++;
      $display("FAIL reset_complete got=%b exp=0", bus.complete);
    end
    checks++;
    if (bus.dout !== 16'h0000) begin
      failures++;
      $display("FAIL reset_dout got=%h exp=0000", bus.dout);
    end
    checks++;
    if (bus6.dout !== 16'h0000) begin
      failures++;
      $display("FAIL reset_dout6 got=%h exp=0000", bus6.dout);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.complete !== 1'b0 || bus.dout !== 16'h0000) begin
      failures++;
      $display("FAIL release_outputs got=%b/%h exp=0/0000", bus.complete, bus.dout);
    end
  endtask

  task automatic test_read;
    bus.rd   = 1'b1;
    bus.addr = 16'h3000;
    bus.din  = 16'h0000;
    do_load(16'h3000, 16'h1234);
    wait_complete(1'b0, cyc);
    checks++;
    if (cyc !== 4) begin
      failures++;
      $display("FAIL read_latency got=%0d exp=4", cyc);
    end
    checks++;
    if (bus.dout !== 16'h1234) begin
      failures++;
      $display("FAIL read_dout got=%h exp=1234", bus.dout);
    end
    tick();
    checks++;
    if (bus.complete !== 1'b0) begin
      failures++;
      $display("FAIL read_pulse_width got=%b exp=0", bus.complete);
    end
    wait_complete(1'b0, cyc);
    checks++;
    if (cyc !== 3) begin
      failures++;
      $display("FAIL read_repeat got=%0d exp=3", cyc);
    end
  endtask

  task automatic test_write_readback;
    bus.rd   = 1'b0;
    bus.addr = 16'h3001;
    bus.din  = 16'hBEEF;
    do_load(16'h00FF, 16'h0000);
    wait_complete(1'b0, cyc);
    checks++;
    if (cyc !== 4) begin
      failures++;
      $display("FAIL write_latency got=%0d exp=4", cyc);
    end
    checks++;
    if (bus.dout !== 16'h1234) begin
      failures++;
      $display("FAIL write_keeps_dout got=%h exp=1234", bus.dout);
    end
    bus.rd   = 1'b1;
    wait_complete(1'b0, cyc);
    checks++;
    if (cyc !== 4 || bus.dout !== 16'hBEEF) begin
      failures++;
      $display("FAIL write_readback got=%0d/%h exp=4/beef", cyc, bus.dout);
    end
  endtask

  task automatic test_abort;
    bus.rd   = 1'b0;
    bus.addr = 16'h3002;
    bus.din  = 16'h5555;
    do_load(16'h3002, 16'h1111);
    tick();
    tick();
    checks++;
    if (bus.complete !== 1'b0) begin
      failures++;
      $display("FAIL abort_early got=%b exp=0", bus.complete);
    end
    bus.addr = 16'h3003;
    wait_complete(1'b0, cyc);
    checks++;
    if (cyc !== 4) begin
      failures++;
      $display("FAIL abort_restart got=%0d exp=4", cyc);
    end
    bus.rd   = 1'b1;
    bus.addr = 16'h3002;
    wait_complete(1'b0, cyc);
    checks++;
    if (cyc !== 4 || bus.dout !== 16'h1111) begin
      failures++;
      $display("FAIL abort_old_word got=%0d/%h exp=4/1111", cyc, bus.dout);
    end
    bus.addr = 16'h3003;
    wait_complete(1'b0, cyc);
    checks++;
    if (cyc !== 4 || bus.dout !== 16'h5555) begin
      failures++;
      $display("FAIL abort_new_word got=%0d/%h exp=4/5555", cyc, bus.dout);
    end
  endtask

  task automatic test_reset_mid_op;
    bus.rd   = 1'b0;
    bus.addr = 16'h3004;
    bus.din  = 16'h7777;
    do_load(16'h3004, 16'h2222);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (bus.complete !== 1'b0 || bus.dout !== 16'h0000) begin
      failures++;
      $display("FAIL midop_reset_outputs got=%b/%h exp=0/0000", bus.complete, bus.dout);
    end
    tick();
    reset  = 1'b0;
    bus.rd = 1'b1;
    wait_complete(1'b0, cyc);
    checks++;
    if (cyc !== 4 || bus.dout !== 16'h2222) begin
      failures++;
      $display("FAIL midop_reset_word got=%0d/%h exp=4/2222", cyc, bus.dout);
    end
  endtask

  task automatic test_load_mid_op;
    bus.rd   = 1'b0;
    bus.addr = 16'h3005;
    bus.din  = 16'h8888;
    do_load(16'h3005, 16'h3333);
    tick();
    tick();
    tick();
    do_load(16'h0100, 16'h4444);
    checks++;
    if (bus.complete !== 1'b0) begin
      failures++;
      $display("FAIL midop_load_complete got=%b exp=0", bus.complete);
    end
    bus.rd = 1'b1;
    wait_complete(1'b0, cyc);
    checks++;
    if (cyc !== 4 || bus.dout !== 16'h3333) begin
      failures++;
      $display("FAIL midop_load_word got=%0d/%h exp=4/3333", cyc, bus.dout);
    end
    bus.addr = 16'h0100;
    wait_complete(1'b0, cyc);
    checks++;
    if (cyc !== 4 || bus.dout !== 16'h4444) begin
      failures++;
      $display("FAIL midop_load_data got=%0d/%h exp=4/4444", cyc, bus.dout);
    end
  endtask

  task automatic test_wrap;
    bus6.rd    = 1'b1;
    bus6.addr  = 16'h0105;
    bus6.din   = 16'h0000;
    load6_en   = 1'b1;
    load6_addr = 16'h0005;
    load6_data = 16'hA5A5;
    tick();
    load6_en   = 1'b0;
    wait_complete(1'b1, cyc);
    checks++;
    if (cyc !== 2) begin
      failures++;
      $display("FAIL wrap_latency got=%0d exp=2", cyc);
    end
    checks++;
    if (bus6.dout !== 16'hA5A5) begin
      failures++;
      $display("FAIL wrap_dout got=%h exp=a5a5", bus6.dout);
    end
  endtask

  initial begin
    reset      = 1'b1;
    load_en    = 1'b0;
    load_addr  = 16'h0000;
    load_data  = 16'h0000;
    load6_en   = 1'b0;
    load6_addr = 16'h0000;
    load6_data = 16'h0000;
    bus.rd     = 1'b1;
    bus.addr   = 16'h0000;
    bus.din    = 16'h0000;
    bus6.rd    = 1'b1;
    bus6.addr  = 16'h0000;
    bus6.din   = 16'h0000;
    test_reset();
    test_read();
    test_write_readback();
    test_abort();
    test_reset_mid_op();
    test_load_mid_op();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
